// File: rtl/alu_arbiter_if.sv
// Request/response bundle between the two issue sources and alu_arbiter.
// master = requester side, slave = arbiter side.
interface alu_arbiter_if #(
    parameter int unsigned DATA_WIDTH = 32
);
    logic                  req0_valid;
    logic                  req0_ready;
    logic [DATA_WIDTH-1:0] req0_a;
    logic [DATA_WIDTH-1:0] req0_b;
    logic [2:0]            req0_op;
    logic                  req1_valid;
    logic                  req1_ready;
    logic [DATA_WIDTH-1:0] req1_a;
    logic [DATA_WIDTH-1:0] req1_b;
    logic [2:0]            req1_op;
    logic                  rsp0_valid;
    logic                  rsp0_ready;
    logic                  rsp1_valid;
    logic                  rsp1_ready;
    logic [DATA_WIDTH-1:0] rsp_result;
    logic                  rsp_less;
    logic                  rsp_err;

    modport master (
        output req0_valid, req0_a, req0_b, req0_op,
        output req1_valid, req1_a, req1_b, req1_op,
        output rsp0_ready, rsp1_ready,
        input  req0_ready, req1_ready,
        input  rsp0_valid, rsp1_valid, rsp_result, rsp_less, rsp_err
    );

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_op,
        input  req1_valid, req1_a, req1_b, req1_op,
        input  rsp0_ready, rsp1_ready,
        output req0_ready, req1_ready,
        output rsp0_valid, rsp1_valid, rsp_result, rsp_less, rsp_err
    );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one combinational ALU between two requesters, one op in flight.
// Define ALU_ARB_OPCHECK_EN to flag opcodes 011/100/101 as illegal via rsp_err.
module alu_arbiter #(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    alu_arbiter_if.slave          bus,
    output logic [DATA_WIDTH-1:0] alu_a,
    output logic [DATA_WIDTH-1:0] alu_b,
    output logic [2:0]            alu_opcode,
    input  logic [DATA_WIDTH-1:0] alu_out,
    input  logic                  alu_less
);
    localparam logic [2:0] OP_SLT = 3'b111;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } state_t;

    state_t                state;
    logic                  last;
    logic                  owner;
    logic                  grant0;
    logic                  grant1;
    logic                  accept;
    logic                  consume;
    logic [DATA_WIDTH-1:0] sel_a;
    logic [DATA_WIDTH-1:0] sel_b;
    logic [2:0]            sel_op;
    logic [DATA_WIDTH-1:0] exec_result;
    logic                  exec_less;
    logic                  rsp0_valid_q;
    logic                  rsp1_valid_q;
    logic [DATA_WIDTH-1:0] result_q;
    logic                  less_q;
`ifdef ALU_ARB_OPCHECK_EN
    logic                  sel_illegal;
    logic                  op_err;
    logic                  err_q;
`endif

    // last==1 means req1 was served most recently, so req0 wins a tie
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (state == IDLE) begin
            if (bus.req0_valid && bus.req1_valid) begin
                grant0 = last;
                grant1 = ~last;
            end else begin
                grant0 = bus.req0_valid;
                grant1 = bus.req1_valid;
            end
        end
    end

    assign accept = grant0 | grant1;
    assign sel_a  = grant1 ? bus.req1_a  : bus.req0_a;
    assign sel_b  = grant1 ? bus.req1_b  : bus.req0_b;
    assign sel_op = grant1 ? bus.req1_op : bus.req0_op;

    assign consume = owner ? bus.rsp1_ready : bus.rsp0_ready;

`ifdef ALU_ARB_OPCHECK_EN
    assign sel_illegal = (sel_op == 3'b011) || (sel_op == 3'b100) || (sel_op == 3'b101);
`endif

    always_comb begin
        exec_result = alu_out;
        exec_less   = 1'b0;
        if (alu_opcode == OP_SLT) begin
            exec_result = DATA_WIDTH'(alu_less);
            exec_less   = alu_less;
        end
`ifdef ALU_ARB_OPCHECK_EN
        // alu_opcode is stale for an illegal op, so the error overrides it
        if (op_err) begin
            exec_result = '0;
            exec_less   = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            last         <= 1'b1;
            owner        <= 1'b0;
            alu_a        <= '0;
            alu_b        <= '0;
            alu_opcode   <= '0;
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
            result_q     <= '0;
            less_q       <= 1'b0;
`ifdef ALU_ARB_OPCHECK_EN
            op_err       <= 1'b0;
            err_q        <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        owner <= grant1;
                        last  <= grant1;
                        state <= EXEC;
`ifdef ALU_ARB_OPCHECK_EN
                        op_err <= sel_illegal;
                        if (!sel_illegal) begin
                            alu_a      <= sel_a;
                            alu_b      <= sel_b;
                            alu_opcode <= sel_op;
                        end
`else
                        alu_a      <= sel_a;
                        alu_b      <= sel_b;
                        alu_opcode <= sel_op;
`endif
                    end
                end
                EXEC: begin
                    result_q     <= exec_result;
                    less_q       <= exec_less;
                    rsp0_valid_q <= ~owner;
                    rsp1_valid_q <= owner;
`ifdef ALU_ARB_OPCHECK_EN
                    err_q        <= op_err;
`endif
                    state        <= RESP;
                end
                RESP: begin
                    if (consume) begin
                        rsp0_valid_q <= 1'b0;
                        rsp1_valid_q <= 1'b0;
                        state        <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.req0_ready = grant0;
    assign bus.req1_ready = grant1;
    assign bus.rsp0_valid = rsp0_valid_q;
    assign bus.rsp1_valid = rsp1_valid_q;
    assign bus.rsp_result = result_q;
    assign bus.rsp_less   = less_q;
`ifdef ALU_ARB_OPCHECK_EN
    assign bus.rsp_err    = err_q;
`else
    assign bus.rsp_err    = 1'b0;
`endif
endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural ALU on the alu_* side.
module tb_alu_arbiter;
    localparam int unsigned DW = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [DW-1:0] alu_a;
    logic [DW-1:0] alu_b;
    logic [DW-1:0] alu_out;
    logic [2:0]    alu_opcode;
    logic          alu_less;

    int checks = 0;
    int errors = 0;

    alu_arbiter_if #(.DATA_WIDTH(DW)) bus ();

    alu_arbiter #(.DATA_WIDTH(DW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_opcode (alu_opcode),
        .alu_out    (alu_out),
        .alu_less   (alu_less)
    );

    always #5 clk = ~clk;

    // slt deliberately returns junk on alu_out so the arbiter must substitute alu_less
    always_comb begin
        alu_less = (alu_a < alu_b);
        case (alu_opcode)
            3'b010:  alu_out = alu_a + alu_b;
            3'b110:  alu_out = alu_a - alu_b;
            3'b000:  alu_out = alu_a & alu_b;
            3'b001:  alu_out = alu_a | alu_b;
            3'b111:  alu_out = 32'hA5A5_A5A5;
            default: alu_out = alu_a ^ alu_b;
        endcase
    end

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Called at posedge+1; returns at posedge+1 just after the handshake edge.
    task automatic send(input int who, input logic [DW-1:0] a, input logic [DW-1:0] b,
                        input logic [2:0] op, input string tag);
        bit done = 0;
        if (who == 0) begin
            bus.req0_valid = 1'b1; bus.req0_a = a; bus.req0_b = b; bus.req0_op = op;
        end else begin
            bus.req1_valid = 1'b1; bus.req1_a = a; bus.req1_b = b; bus.req1_op = op;
        end
        #1;
        for (int i = 0; i < 20 && !done; i++) begin
            if ((who == 0 && bus.req0_ready) || (who == 1 && bus.req1_ready)) done = 1;
            @(posedge clk); #1;
        end
        if (!done) check({tag, "_grant_timeout"}, 0, 1);
        if (who == 0) bus.req0_valid = 1'b0;
        else          bus.req1_valid = 1'b0;
    endtask

    task automatic expect_rsp(input int who, input logic [DW-1:0] res, input logic less,
                              input logic err, input string tag);
        bit seen = 0;
        for (int i = 0; i < 10; i++) begin
            if (who == 0 ? bus.rsp0_valid : bus.rsp1_valid) begin
                seen = 1;
                break;
            end
            @(posedge clk); #1;
        end
        check({tag, "_rsp_seen"}, 32'(seen), 1);
        check({tag, "_other_valid"}, 32'(who == 0 ? bus.rsp1_valid : bus.rsp0_valid), 0);
        check({tag, "_result"}, bus.rsp_result, res);
        check({tag, "_less"}, 32'(bus.rsp_less), 32'(less));
        check({tag, "_err"}, 32'(bus.rsp_err), 32'(err));
        if (who == 0) bus.rsp0_ready = 1'b1;
        else          bus.rsp1_ready = 1'b1;
        @(posedge clk); #1;
        bus.rsp0_ready = 1'b0;
        bus.rsp1_ready = 1'b0;
        check({tag, "_rsp_drop"}, 32'(who == 0 ? bus.rsp0_valid : bus.rsp1_valid), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int prev;
        int bad;
        rst_n = 1'b0;
        bus.req0_valid = 0; bus.req0_a = '0; bus.req0_b = '0; bus.req0_op = '0;
        bus.req1_valid = 0; bus.req1_a = '0; bus.req1_b = '0; bus.req1_op = '0;
        bus.rsp0_ready = 0; bus.rsp1_ready = 0;
        #2;
        check("rst_req0_ready", 32'(bus.req0_ready), 0);
        check("rst_rsp0_valid", 32'(bus.rsp0_valid), 0);
        check("rst_rsp1_valid", 32'(bus.rsp1_valid), 0);
        check("rst_result", bus.rsp_result, 0);
        check("rst_less_err", {30'd0, bus.rsp_less, bus.rsp_err}, 0);
        check("rst_alu_a", alu_a, 0);
        check("rst_alu_op", 32'(alu_opcode), 0);
        @(negedge clk); rst_n = 1'b1;

        // single add, exact latency
        @(posedge clk); #1;
        bus.req0_valid = 1; bus.req0_a = 5; bus.req0_b = 3; bus.req0_op = 3'b010;
        #1;
        check("t1_req0_ready", 32'(bus.req0_ready), 1);
        check("t1_req1_ready", 32'(bus.req1_ready), 0);
        @(posedge clk); #1;
        bus.req0_valid = 0;
        check("t1_exec_ready", 32'(bus.req0_ready), 0);
        check("t1_alu_a", alu_a, 5);
        check("t1_alu_b", alu_b, 3);
        check("t1_alu_op", 32'(alu_opcode), 2);
        check("t1_exec_rsp", 32'(bus.rsp0_valid), 0);
        @(posedge clk); #1;
        check("t1_latency", 32'(bus.rsp0_valid), 1);
        expect_rsp(0, 8, 0, 0, "t1");

        // set-less-than from req1
        send(1, 3, 7, 3'b111, "t4a");
        expect_rsp(1, 1, 1, 0, "t4a");
        send(1, 7, 3, 3'b111, "t4b");
        expect_rsp(1, 0, 0, 0, "t4b");

        // tie after req1 was served: req0 first
        bus.req0_valid = 1; bus.req0_a = 7;     bus.req0_b = 9;     bus.req0_op = 3'b110;
        bus.req1_valid = 1; bus.req1_a = 'hF0;  bus.req1_b = 'h0F;  bus.req1_op = 3'b001;
        #1;
        check("t2_req0_ready", 32'(bus.req0_ready), 1);
        check("t2_req1_ready", 32'(bus.req1_ready), 0);
        @(posedge clk); #1;
        bus.req0_valid = 0;
        expect_rsp(0, 32'hFFFF_FFFE, 0, 0, "t2a");
        send(1, 'hF0, 'h0F, 3'b001, "t2b");
        expect_rsp(1, 32'hFF, 0, 0, "t2b");

        // continuous contention, ready tied high
        bus.req0_valid = 1; bus.req0_a = 1;  bus.req0_b = 2; bus.req0_op = 3'b010;
        bus.req1_valid = 1; bus.req1_a = 10; bus.req1_b = 3; bus.req1_op = 3'b110;
        bus.rsp0_ready = 1; bus.rsp1_ready = 1;
        n = 0;
        prev = 0;
        for (int cyc = 0; cyc < 40 && n < 6; cyc++) begin
            #1;
            if (bus.req0_ready || bus.req1_ready) begin
                check($sformatf("t3_grant%0d", n), 32'(bus.req1_ready), 32'(n % 2));
                if (n > 0) check($sformatf("t3_gap%0d", n), 32'(cyc - prev), 3);
                prev = cyc;
                n++;
            end
            @(posedge clk);
        end
        #1;
        bus.req0_valid = 0;
        bus.req1_valid = 0;
        check("t3_count", 32'(n), 6);
        repeat (3) @(posedge clk);
        #1;
        bus.rsp0_ready = 0;
        bus.rsp1_ready = 0;
        check("t3_idle_rsp1", 32'(bus.rsp1_valid), 0);

        // stall owner response while req1 waits; non-owner ready ignored
        send(0, 'h1234, 1, 3'b010, "t5a");
        bus.req1_valid = 1; bus.req1_a = 10; bus.req1_b = 20; bus.req1_op = 3'b010;
        bus.rsp1_ready = 1;
        @(posedge clk); #1;
        bad = 0;
        repeat (10) begin
            if (!bus.rsp0_valid || bus.rsp_result !== 32'h1235 || bus.req1_ready || bus.rsp1_valid)
                bad++;
            @(posedge clk); #1;
        end
        check("t5_stall", 32'(bad), 0);
        check("t5_hold_valid", 32'(bus.rsp0_valid), 1);
        check("t5_hold_result", bus.rsp_result, 32'h1235);
        bus.rsp1_ready = 0;
        bus.rsp0_ready = 1;
        @(posedge clk); #1;
        bus.rsp0_ready = 0;
        check("t5_release", 32'(bus.rsp0_valid), 0);
        check("t5_req1_ready", 32'(bus.req1_ready), 1);
        send(1, 10, 20, 3'b010, "t5b");
        expect_rsp(1, 30, 0, 0, "t5b");

        // reset during EXEC
        send(0, 5, 5, 3'b010, "t6a");
        #1 rst_n = 1'b0;
        #1;
        check("t6_rsp0_valid", 32'(bus.rsp0_valid), 0);
        check("t6_result", bus.rsp_result, 0);
        check("t6_alu_a", alu_a, 0);
        check("t6_alu_op", 32'(alu_opcode), 0);
        check("t6_req0_ready", 32'(bus.req0_ready), 0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        bus.req0_valid = 1; bus.req0_a = 1; bus.req0_b = 1; bus.req0_op = 3'b010;
        bus.req1_valid = 1; bus.req1_a = 2; bus.req1_b = 2; bus.req1_op = 3'b010;
        #1;
        check("t6_tie_req0", 32'(bus.req0_ready), 1);
        check("t6_tie_req1", 32'(bus.req1_ready), 0);
        @(posedge clk); #1;
        bus.req0_valid = 0;
        expect_rsp(0, 2, 0, 0, "t6b");
        send(1, 2, 2, 3'b010, "t6c");
        expect_rsp(1, 4, 0, 0, "t6c");

`ifdef ALU_ARB_OPCHECK_EN
        send(0, 9, 6, 3'b100, "t7");
        expect_rsp(0, 0, 0, 1, "t7");
        check("t7_alu_op_kept", 32'(alu_opcode), 2);
        check("t7_alu_a_kept", alu_a, 2);
`else
        send(0, 9, 6, 3'b100, "t7");
        expect_rsp(0, 32'hF, 0, 0, "t7");
        check("t7_alu_op_pass", 32'(alu_opcode), 4);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
